// File: rtl/rx_capture_pkg.sv
// Shared types and defaults for the receive line-capture block.
package rx_capture_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_TAG_W  = 4;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READY   = 2'd3
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_line_capture_if.sv
// Bus bundle between the capture block (master) and its environment (slave).
interface rx_line_capture_if
    import rx_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAG_W  = DEF_TAG_W
);
    logic                     sample_gate;
    logic [DATA_W-1:0]        adc_data;
    logic [15:0]              dly;
    logic [2:0]               decim;

    logic                     buf_we;
    logic [ADDR_W-1:0]        buf_addr;
    logic [DATA_W+TAG_W-1:0]  buf_wdata;

    // Line handshake: line_ready stays high (with line_len/line_cnt frozen) until the
    // reader pulses line_ack; an ack seen while line_ready is low has no effect.
    logic                     line_ready;
    logic [ADDR_W:0]          line_len;
    logic                     line_ack;
    logic [15:0]              line_cnt;
    logic [7:0]               drop_cnt;

    modport master (
        input  sample_gate, adc_data, dly, decim, line_ack,
        output buf_we, buf_addr, buf_wdata, line_ready, line_len, line_cnt, drop_cnt
    );

    modport slave (
        output sample_gate, adc_data, dly, decim, line_ack,
        input  buf_we, buf_addr, buf_wdata, line_ready, line_len, line_cnt, drop_cnt
    );

endinterface

// File: rtl/rx_gate_edge.sv
// Registers Sample_Gate and produces single-cycle rise/fall pulses against the previous value.
module rx_gate_edge (
    input  logic clk_in,
    input  logic reset_n,
    input  logic gate,
    output logic rise,
    output logic fall
);
    logic gate_q, gate_d;

    always_comb begin
        gate_d = gate;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate_d;
        end
    end

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

endmodule

// File: rtl/rx_line_capture.sv
// Captures one delayed, decimated, line-tagged echo line per gate firing and holds it for a reader.
// Optional feature macro RX_CAPTURE_DROP_CNT_EN: when undefined, drop_cnt is tied to 0.
module rx_line_capture
    import rx_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              clk_in,
    input  logic              reset_n,
    rx_line_capture_if.master bus,
    output state_e            state_dbg
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int WD_W  = DATA_W + TAG_W;

    logic rise;
    logic fall;

    rx_gate_edge u_gate_edge (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .gate    (bus.sample_gate),
        .rise    (rise),
        .fall    (fall)
    );

    state_e            state_q,    state_d;
    logic [15:0]       dly_cnt_q,  dly_cnt_d;
    logic [2:0]        decim_q,    decim_d;
    logic [2:0]        phase_q,    phase_d;
    logic [LEN_W-1:0]  wr_cnt_q,   wr_cnt_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [WD_W-1:0]   wdata_q,    wdata_d;
    logic              ready_q,    ready_d;
    logic [LEN_W-1:0]  len_q,      len_d;
    logic [15:0]       line_cnt_q, line_cnt_d;

    always_comb begin
        state_d    = state_q;
        dly_cnt_d  = dly_cnt_q;
        decim_d    = decim_q;
        phase_d    = phase_q;
        wr_cnt_d   = wr_cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        len_d      = len_q;
        line_cnt_d = line_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    dly_cnt_d = bus.dly - 16'd1;
                    decim_d   = bus.decim;
                    phase_d   = 3'd0;
                    wr_cnt_d  = '0;
                    state_d   = (bus.dly == 16'd0) ? ST_CAPTURE : ST_DELAY;
                end
            end
            ST_DELAY: begin
                // A gate that closes before the delay expires still produces an (empty) line.
                if (fall) begin
                    state_d = ST_READY;
                end else if (dly_cnt_q == 16'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    dly_cnt_d = dly_cnt_q - 16'd1;
                end
            end
            ST_CAPTURE: begin
                // wr_cnt MSB set means the last address was sampled; its write lands this cycle.
                if (fall || wr_cnt_q[ADDR_W]) begin
                    state_d = ST_READY;
                end else begin
                    if (phase_q == 3'd0) begin
                        we_d     = 1'b1;
                        addr_d   = wr_cnt_q[ADDR_W-1:0];
                        wdata_d  = {line_cnt_q[TAG_W-1:0], bus.adc_data};
                        wr_cnt_d = wr_cnt_q + LEN_W'(1);
                    end
                    phase_d = (phase_q == decim_q) ? 3'd0 : phase_q + 3'd1;
                end
            end
            ST_READY: begin
                if (bus.line_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_READY && state_d == ST_READY) begin
            len_d      = wr_cnt_q;
            line_cnt_d = line_cnt_q + 16'd1;
        end

        ready_d = (state_d == ST_READY);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            dly_cnt_q  <= '0;
            decim_q    <= '0;
            phase_q    <= '0;
            wr_cnt_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            len_q      <= '0;
            line_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dly_cnt_q  <= dly_cnt_d;
            decim_q    <= decim_d;
            phase_q    <= phase_d;
            wr_cnt_q   <= wr_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            len_q      <= len_d;
            line_cnt_q <= line_cnt_d;
        end
    end

`ifdef RX_CAPTURE_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    // Any rise outside IDLE is a lost firing, including one coinciding with the ack.
    always_comb begin
        drop_d = drop_q;
        if (rise && state_q != ST_IDLE) begin
            drop_d = sat_inc8(drop_q);
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.buf_we     = we_q;
    assign bus.buf_addr   = addr_q;
    assign bus.buf_wdata  = wdata_q;
    assign bus.line_ready = ready_q;
    assign bus.line_len   = len_q;
    assign bus.line_cnt   = line_cnt_q;
    assign state_dbg      = state_q;

endmodule
